// File: rtl/lot_pkg.sv
// lot_pkg: gate state encoding and default sizing shared by the lot entry/exit controllers
package lot_pkg;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_OPEN    = 2'd1;
  localparam logic [1:0] ST_CLOSING = 2'd2;
  localparam int DEF_CAPACITY     = 8;
  localparam int DEF_CW           = 4;
  localparam int DEF_OPEN_CYCLES  = 16;
  localparam int DEF_CLOSE_CYCLES = 4;
endpackage

// File: rtl/lot_gate_ctrl_if.sv
// lot_gate_ctrl_if: sensor pulses in, barrier command and occupancy status out
interface lot_gate_ctrl_if
  import lot_pkg::*;
#(
  parameter int CW = DEF_CW
) ();
  logic          req;
  logic          entry_done;
  logic          exit_done;
  logic          gate_open;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          err;
  modport master (output req, entry_done, exit_done, input gate_open, full, empty, count, err);
  modport slave  (input req, entry_done, exit_done, output gate_open, full, empty, count, err);
endinterface

// File: rtl/lot_occupancy.sv
// lot_occupancy: saturating up/down car counter with over/underflow strobe
module lot_occupancy
  import lot_pkg::*;
#(
  parameter int CAPACITY = DEF_CAPACITY,
  parameter int CW       = DEF_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_i,
  input  logic          out_i,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          ovf_o
);
  logic [CW-1:0] count_q, count_d;
  logic          up, dn;
  assign full_o  = count_q == CW'(CAPACITY);
  assign empty_o = count_q == '0;
  assign up      = in_i && !out_i;
  assign dn      = out_i && !in_i;
  assign ovf_o   = (up && full_o) || (dn && empty_o);
  assign count_o = count_q;
  always_comb begin
    count_d = (up && !full_o) ? count_q + 1'b1 : (dn && !empty_o) ? count_q - 1'b1 : count_q;
  end
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end
endmodule

// File: rtl/lot_gate_ctrl.sv
// lot_gate_ctrl: entry barrier sequencer (IDLE/OPEN/CLOSING) with occupancy tracking
module lot_gate_ctrl
  import lot_pkg::*;
#(
  parameter int CAPACITY     = DEF_CAPACITY,
  parameter int CW           = DEF_CW,
  parameter int OPEN_CYCLES  = DEF_OPEN_CYCLES,
  parameter int CLOSE_CYCLES = DEF_CLOSE_CYCLES
) (
  input logic             clk,
  input logic             reset,
  lot_gate_ctrl_if.slave  bus
);
  localparam int TW = $clog2(OPEN_CYCLES > CLOSE_CYCLES ? OPEN_CYCLES : CLOSE_CYCLES);
  logic [1:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          gate_open_q, err_q, err_d, ovf;
  lot_occupancy #(.CAPACITY(CAPACITY), .CW(CW)) u_occ (
    .clk     (clk),
    .reset   (reset),
    .in_i    (bus.entry_done),
    .out_i   (bus.exit_done),
    .count_o (bus.count),
    .full_o  (bus.full),
    .empty_o (bus.empty),
    .ovf_o   (ovf)
  );
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 1'b1;
    if (state_q == ST_IDLE) begin
      timer_d = '0;
      if (bus.req && !bus.full) state_d = ST_OPEN;
    end else if (state_q == ST_OPEN) begin
      if (bus.entry_done || timer_q == TW'(OPEN_CYCLES - 1)) begin
        state_d = ST_CLOSING;
        timer_d = '0;
      end
    end else if (timer_q == TW'(CLOSE_CYCLES - 1)) begin
      state_d = ST_IDLE;
      timer_d = '0;
    end
  end
  // a passage seen outside OPEN is tailgating or a sensor fault
  assign err_d = err_q || ovf || (bus.entry_done && state_q != ST_OPEN);
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      gate_open_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      gate_open_q <= state_d == ST_OPEN;
      err_q       <= err_d;
    end
  end
  assign bus.gate_open = gate_open_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_lot_gate_ctrl.sv
// tb_lot_gate_ctrl: directed vector table plus hand-written multi-cycle sequences
module tb_lot_gate_ctrl;
  typedef struct {
    logic       req, en, ex;
    logic       gate;
    logic [3:0] count;
    logic       full, empty, err;
  } vec_t;
  logic clk = 1'b0;
  logic reset;
  int total = 0;
  int bad = 0;
  vec_t vecs[13];
  lot_gate_ctrl_if #(.CW(4)) bus ();
  lot_gate_ctrl #(.CAPACITY(8), .CW(4), .OPEN_CYCLES(16), .CLOSE_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask
  task automatic cyc(input logic r, input logic en, input logic ex);
    bus.req = r;
    bus.entry_done = en;
    bus.exit_done = ex;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    cyc(0, 0, 0);
    reset = 1'b0;
  endtask
  task automatic enter_car();
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    repeat (4) cyc(0, 0, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    logic stuck;
    vecs[0]  = '{1, 0, 0, 1, 0, 0, 1, 0};
    vecs[1]  = '{0, 0, 0, 1, 0, 0, 1, 0};
    vecs[2]  = '{0, 0, 0, 1, 0, 0, 1, 0};
    vecs[3]  = '{0, 0, 0, 1, 0, 0, 1, 0};
    vecs[4]  = '{0, 1, 0, 0, 1, 0, 0, 0};
    vecs[5]  = '{1, 0, 0, 0, 1, 0, 0, 0};
    vecs[6]  = '{1, 0, 0, 0, 1, 0, 0, 0};
    vecs[7]  = '{1, 0, 0, 0, 1, 0, 0, 0};
    vecs[8]  = '{1, 0, 0, 0, 1, 0, 0, 0};
    vecs[9]  = '{1, 0, 0, 1, 1, 0, 0, 0};
    vecs[10] = '{0, 1, 0, 0, 2, 0, 0, 0};
    vecs[11] = '{0, 0, 1, 0, 1, 0, 0, 0};
    vecs[12] = '{0, 0, 0, 0, 1, 0, 0, 0};
    bus.req = 0;
    bus.entry_done = 0;
    bus.exit_done = 0;
    do_reset();
    chk("rst_gate", bus.gate_open, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_full", bus.full, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_err", bus.err, 0);
    for (int i = 0; i < 13; i++) begin
      cyc(vecs[i].req, vecs[i].en, vecs[i].ex);
      chk($sformatf("v%0d_gate", i), bus.gate_open, vecs[i].gate);
      chk($sformatf("v%0d_count", i), bus.count, vecs[i].count);
      chk($sformatf("v%0d_full", i), bus.full, vecs[i].full);
      chk($sformatf("v%0d_empty", i), bus.empty, vecs[i].empty);
      chk($sformatf("v%0d_err", i), bus.err, vecs[i].err);
    end
    // timeout: gate open for exactly OPEN_CYCLES samples
    do_reset();
    cyc(1, 0, 0);
    n = 0;
    for (int i = 0; i < 40 && bus.gate_open; i++) begin
      n++;
      cyc(0, 0, 0);
    end
    chk("timeout_open_cycles", n, 16);
    chk("timeout_count", bus.count, 0);
    chk("timeout_err", bus.err, 0);
    // fill the lot, then refuse entry until a car leaves
    do_reset();
    repeat (8) enter_car();
    chk("full_count", bus.count, 8);
    chk("full_flag", bus.full, 1);
    chk("full_err", bus.err, 0);
    stuck = 0;
    repeat (20) begin
      cyc(1, 0, 0);
      if (bus.gate_open) stuck = 1;
    end
    chk("full_gate_refused", stuck, 0);
    cyc(1, 0, 1);
    chk("exit_count", bus.count, 7);
    chk("exit_full", bus.full, 0);
    chk("exit_gate", bus.gate_open, 0);
    cyc(1, 0, 0);
    chk("reopen_gate", bus.gate_open, 1);
    // simultaneous entry and exit while OPEN
    do_reset();
    repeat (3) enter_car();
    cyc(1, 0, 0);
    cyc(0, 1, 1);
    chk("simul_count", bus.count, 3);
    chk("simul_err", bus.err, 0);
    chk("simul_gate", bus.gate_open, 0);
    // underflow is sticky until reset
    do_reset();
    cyc(0, 0, 1);
    chk("uflow_count", bus.count, 0);
    chk("uflow_err", bus.err, 1);
    repeat (5) cyc(0, 0, 0);
    chk("uflow_err_held", bus.err, 1);
    do_reset();
    chk("uflow_err_cleared", bus.err, 0);
    // tailgating in IDLE
    repeat (2) enter_car();
    cyc(0, 1, 0);
    chk("tail_count", bus.count, 3);
    chk("tail_err", bus.err, 1);
    chk("tail_gate", bus.gate_open, 0);
    // reset while the gate is open
    do_reset();
    cyc(0, 1, 0);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("pre_rst_gate", bus.gate_open, 1);
    do_reset();
    chk("mid_rst_gate", bus.gate_open, 0);
    chk("mid_rst_count", bus.count, 0);
    chk("mid_rst_err", bus.err, 0);
    cyc(1, 0, 0);
    chk("post_rst_open", bus.gate_open, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
